// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserialises an idle-high, LSB-first serial line into DATA_W-bit frames:
//   start bit (0), DATA_W data bits, optional even-parity bit, stop bit (1).
//   Bits are only sampled in cycles where bit_valid=1, so the line may be
//   paced arbitrarily by the upstream shifter. Completed frames land in a
//   single holding register with a valid/ready handshake. Reception never
//   stalls: a frame that completes while the holder is full and not being
//   drained is dropped and reported through overrun.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   bit_valid   qualifies ser_in for this cycle
//   ser_in      serial line (idle high, LSB first)
//   data_out    payload of the last accepted frame
//   data_valid  data_out / parity_err are valid
//   data_ready  consumer accepts data_out when data_valid=1
//   parity_err  parity mismatch flag for data_out (0 when PARITY_EN=0)
//   frame_err   one-cycle pulse when the stop bit is sampled as 0
//   overrun     one-cycle pulse when a completed frame is dropped
module serial_frame_receiver #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              ser_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // Wide enough to hold DATA_W itself, so the count never wraps in a frame.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_pend_q, perr_pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic              stop_sample;
  logic              frame_done;

  // ---- state register and all flops ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      case (state_q)
        IDLE:    if (!ser_in) state_d = DATA;
        DATA:    if (cnt_q == LAST_CNT) state_d = PARITY_EN ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---- datapath and output-stage logic ----
  assign stop_sample = bit_valid && (state_q == STOP);
  assign frame_done  = stop_sample && ser_in;

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;

    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (!ser_in) begin
            cnt_d       = '0;
            perr_pend_d = 1'b0;
          end
        end
        DATA: begin
          // Right shift in from the MSB end: first bit received ends at bit 0.
          shift_d         = shift_q >> 1;
          shift_d[DATA_W-1] = ser_in;
          cnt_d           = cnt_q + CNT_W'(1);
        end
        PARITY: begin
          // Even parity: data bits XOR parity bit must be 0.
          perr_pend_d = PARITY_EN & ((^shift_q) ^ ser_in);
        end
        default: ;
      endcase
    end

    // A bad stop bit only raises the pulse; the holding register is untouched.
    ferr_d = stop_sample && !ser_in;

    if (frame_done) begin
      if (!valid_q || data_ready) begin
        // Empty holder, or old word leaving this cycle: load with no bubble.
        data_d  = shift_q;
        perr_d  = perr_pend_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
